// File: rtl/ref_scan_sched_if.sv
// Read-side bundle between the reference scan scheduler and its environment (PE array, preload control).
interface ref_scan_sched_if #(
  parameter int ADDR_W = 7
);
  logic              start;
  logic              pre_done;
  logic              pe_ready;
  logic              abort;
  logic [ADDR_W-1:0] rd_address;
  logic [3:0]        rdR_sel;
  logic              rd8R_en;
  logic              row_valid;
  logic              pt_first;
  logic              pt_last;
  logic [3:0]        cand_vx;
  logic [5:0]        cand_vy;
  logic              busy;
  logic              done;

  modport master (
    input  start, pre_done, pe_ready, abort,
    output rd_address, rdR_sel, rd8R_en, row_valid, pt_first, pt_last,
           cand_vx, cand_vy, busy, done
  );

  modport slave (
    output start, pre_done, pe_ready, abort,
    input  rd_address, rdR_sel, rd8R_en, row_valid, pt_first, pt_last,
           cand_vx, cand_vy, busy, done
  );
endinterface

// File: rtl/ref_scan_sched.sv
// Steps (vx, vy) search points and issues BLK_ROWS row reads per point to the reference banks,
// one read per pe_ready cycle; each read comes back one cycle later as row_valid with point tags.
module ref_scan_sched #(
  parameter int BLK_ROWS = 32,
  parameter int V_POS    = 64,
  parameter int H_POS    = 16,
  parameter int ADDR_W   = 7
) (
  input logic        clk,
  input logic        rst,
  ref_scan_sched_if.master bus
);
  localparam int              RC_W     = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;
  localparam logic [RC_W-1:0] ROW_LAST = RC_W'(BLK_ROWS - 1);
  localparam logic [5:0]      VY_LAST  = 6'(V_POS - 1);
  localparam logic [3:0]      VX_LAST  = 4'(H_POS - 1);

  if ((V_POS + BLK_ROWS - 1 > 96) || (H_POS > 16)) begin : g_bad_params
    $error("ref_scan_sched: search window exceeds reference memory");
  end

  typedef enum logic [2:0] {IDLE, WAIT_PRE, SCAN, DRAIN, FIN} state_t;
  state_t state, next_state;

  logic [RC_W-1:0]   row_cnt;
  logic [5:0]        vy;
  logic [3:0]        vx;
  logic              issue, last_issue, abort_hit;

  // Tags captured at issue, presented with the returning row one cycle later
  logic              iss_first, iss_last;
  logic [3:0]        iss_vx;
  logic [5:0]        iss_vy;

  logic [ADDR_W-1:0] rd_address_q;
  logic [3:0]        rdr_sel_q, cand_vx_q;
  logic [5:0]        cand_vy_q;
  logic              rd8r_en_q, row_valid_q, pt_first_q, pt_last_q, busy_q, done_q;

  always_comb begin
    abort_hit  = bus.abort && (state != IDLE);
    issue      = (state == SCAN) && bus.pe_ready && !bus.abort;
    last_issue = issue && (row_cnt == ROW_LAST) && (vy == VY_LAST) && (vx == VX_LAST);
    next_state = state;
    if (abort_hit) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:     if (bus.start) next_state = WAIT_PRE;
        WAIT_PRE: if (bus.pre_done) next_state = SCAN;
        SCAN:     if (last_issue) next_state = DRAIN;
        DRAIN:    next_state = FIN;
        FIN:      next_state = IDLE;
        default:  next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= '0;
      vy      <= '0;
      vx      <= '0;
    end else if (abort_hit || ((state == IDLE) && bus.start)) begin
      row_cnt <= '0;
      vy      <= '0;
      vx      <= '0;
    end else if (issue) begin
      if (row_cnt == ROW_LAST) begin
        row_cnt <= '0;
        if (vy == VY_LAST) begin
          vy <= '0;
          vx <= vx + 4'd1;
        end else begin
          vy <= vy + 6'd1;
        end
      end else begin
        row_cnt <= row_cnt + RC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_address_q <= '0;
      rdr_sel_q    <= '0;
      rd8r_en_q    <= 1'b1;
      iss_first    <= 1'b0;
      iss_last     <= 1'b0;
      iss_vx       <= '0;
      iss_vy       <= '0;
      row_valid_q  <= 1'b0;
      pt_first_q   <= 1'b0;
      pt_last_q    <= 1'b0;
      cand_vx_q    <= '0;
      cand_vy_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rd8r_en_q <= !issue;
      if (issue) begin
        rd_address_q <= ADDR_W'(vy) + ADDR_W'(row_cnt);
        rdr_sel_q    <= vx;
        iss_first    <= (row_cnt == '0);
        iss_last     <= (row_cnt == ROW_LAST);
        iss_vx       <= vx;
        iss_vy       <= vy;
      end
      // An abort discards the row still in flight from the previous read
      row_valid_q <= !rd8r_en_q && !abort_hit;
      if (!rd8r_en_q && !abort_hit) begin
        pt_first_q <= iss_first;
        pt_last_q  <= iss_last;
        cand_vx_q  <= iss_vx;
        cand_vy_q  <= iss_vy;
      end else begin
        pt_first_q <= 1'b0;
        pt_last_q  <= 1'b0;
      end
      busy_q <= (next_state != IDLE);
      done_q <= (next_state == FIN);
    end
  end

  assign bus.rd_address = rd_address_q;
  assign bus.rdR_sel    = rdr_sel_q;
  assign bus.rd8R_en    = rd8r_en_q;
  assign bus.row_valid  = row_valid_q;
  assign bus.pt_first   = pt_first_q;
  assign bus.pt_last    = pt_last_q;
  assign bus.cand_vx    = cand_vx_q;
  assign bus.cand_vy    = cand_vy_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_ref_scan_sched.sv
// Bench for ref_scan_sched: a small (4x3x2) and a default-size instance checked against a read-order scoreboard.
module tb_ref_scan_sched;
  typedef struct {
    int addr;
    int sel;
    bit first;
    bit last;
    int vx;
    int vy;
  } rd_t;

  logic clk = 1'b0;
  logic rst_s, rst_d;
  always #5 clk = ~clk;

  ref_scan_sched_if #(.ADDR_W(7)) bs();
  ref_scan_sched_if #(.ADDR_W(7)) bd();

  ref_scan_sched #(.BLK_ROWS(4), .V_POS(3), .H_POS(2), .ADDR_W(7)) dut_s (
    .clk(clk), .rst(rst_s), .bus(bs)
  );
  ref_scan_sched #(.BLK_ROWS(32), .V_POS(64), .H_POS(16), .ADDR_W(7)) dut_d (
    .clk(clk), .rst(rst_d), .bus(bd)
  );

  logic [6:0] a_addr [2];
  logic [3:0] a_sel [2], a_vx [2];
  logic [5:0] a_vy [2];
  logic       a_en [2], a_rv [2], a_pf [2], a_pl [2], a_busy [2], a_done [2];

  assign a_addr[0] = bs.rd_address;  assign a_addr[1] = bd.rd_address;
  assign a_sel[0]  = bs.rdR_sel;     assign a_sel[1]  = bd.rdR_sel;
  assign a_en[0]   = bs.rd8R_en;     assign a_en[1]   = bd.rd8R_en;
  assign a_rv[0]   = bs.row_valid;   assign a_rv[1]   = bd.row_valid;
  assign a_pf[0]   = bs.pt_first;    assign a_pf[1]   = bd.pt_first;
  assign a_pl[0]   = bs.pt_last;     assign a_pl[1]   = bd.pt_last;
  assign a_vx[0]   = bs.cand_vx;     assign a_vx[1]   = bd.cand_vx;
  assign a_vy[0]   = bs.cand_vy;     assign a_vy[1]   = bd.cand_vy;
  assign a_busy[0] = bs.busy;        assign a_busy[1] = bd.busy;
  assign a_done[0] = bs.done;        assign a_done[1] = bd.done;

  int   vectors = 0;
  int   miscompares = 0;
  rd_t  q_rd [2][$];
  rd_t  q_tag [2][$];
  int   nrd [2], nrv [2], nfirst [2], nlast [2], max_addr [2], last_vx [2], last_vy [2];
  int   obs_addr[$], obs_sel[$];
  int   exp12 [12] = '{0, 1, 2, 3, 1, 2, 3, 4, 2, 3, 4, 5};
  int   cyc;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected read order: vx outermost, then vy, then row within the block
  task automatic push_scan(input int i, input int br, input int vp, input int hp);
    rd_t e;
    for (int x = 0; x < hp; x++)
      for (int y = 0; y < vp; y++)
        for (int r = 0; r < br; r++) begin
          e.addr = y + r;   e.sel = x;
          e.first = (r == 0); e.last = (r == br - 1);
          e.vx = x;         e.vy = y;
          q_rd[i].push_back(e);
          q_tag[i].push_back(e);
        end
  endtask

  task automatic clr_stats(input int i);
    nrd[i] = 0; nrv[i] = 0; nfirst[i] = 0; nlast[i] = 0;
    max_addr[i] = 0; last_vx[i] = -1; last_vy[i] = -1;
    q_rd[i].delete();
    q_tag[i].delete();
    if (i == 0) begin
      obs_addr.delete();
      obs_sel.delete();
    end
  endtask

  task automatic check_reset(input int i);
    chk("rst_rd_address", int'(a_addr[i]), 0);
    chk("rst_rdR_sel", int'(a_sel[i]), 0);
    chk("rst_rd8R_en", int'(a_en[i]), 1);
    chk("rst_row_valid", int'(a_rv[i]), 0);
    chk("rst_pt_first", int'(a_pf[i]), 0);
    chk("rst_pt_last", int'(a_pl[i]), 0);
    chk("rst_cand_vx", int'(a_vx[i]), 0);
    chk("rst_cand_vy", int'(a_vy[i]), 0);
    chk("rst_busy", int'(a_busy[i]), 0);
    chk("rst_done", int'(a_done[i]), 0);
  endtask

  task automatic wait_done(input int i, input int budget, input bit tog, output int n);
    bit pr, seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      pr = (i == 0) ? bs.pe_ready : bd.pe_ready;
      tick();
      n++;
      if (tog && i == 0) begin
        if (!bs.rd8R_en) chk("read_only_when_ready", int'(pr), 1);
        bs.pe_ready = ~bs.pe_ready;
      end
      seen = (i == 0) ? bs.done : bd.done;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic check_totals(input int i, input int reads, input int pts);
    chk("reads_issued", nrd[i], reads);
    chk("rows_valid", nrv[i], reads);
    chk("pt_first_count", nfirst[i], pts);
    chk("pt_last_count", nlast[i], pts);
    chk("reads_left", q_rd[i].size(), 0);
    chk("tags_left", q_tag[i].size(), 0);
  endtask

  always @(negedge clk) begin : cmp
    rd_t e;
    for (int i = 0; i < 2; i++) begin
      if (!a_en[i]) begin
        if (q_rd[i].size() == 0) chk("unexpected_read", 1, 0);
        else begin
          e = q_rd[i].pop_front();
          chk("rd_address", int'(a_addr[i]), e.addr);
          chk("rdR_sel", int'(a_sel[i]), e.sel);
          nrd[i]++;
          if (int'(a_addr[i]) > max_addr[i]) max_addr[i] = int'(a_addr[i]);
          if (i == 0) begin
            obs_addr.push_back(int'(a_addr[i]));
            obs_sel.push_back(int'(a_sel[i]));
          end
        end
      end
      if (a_rv[i]) begin
        if (q_tag[i].size() == 0) chk("unexpected_row_valid", 1, 0);
        else begin
          e = q_tag[i].pop_front();
          chk("pt_first", int'(a_pf[i]), int'(e.first));
          chk("pt_last", int'(a_pl[i]), int'(e.last));
          chk("cand_vx", int'(a_vx[i]), e.vx);
          chk("cand_vy", int'(a_vy[i]), e.vy);
          nrv[i]++;
          nfirst[i] += int'(a_pf[i]);
          if (a_pl[i]) begin
            nlast[i]++;
            last_vx[i] = int'(a_vx[i]);
            last_vy[i] = int'(a_vy[i]);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_s = 1'b1; rst_d = 1'b1;
    bs.start = 0; bs.pre_done = 0; bs.pe_ready = 0; bs.abort = 0;
    bd.start = 0; bd.pre_done = 0; bd.pe_ready = 0; bd.abort = 0;
    clr_stats(0);
    clr_stats(1);
    repeat (3) tick();
    rst_s = 1'b0; rst_d = 1'b0;
    tick();
    check_reset(0);
    check_reset(1);

    // Nominal small scan, always ready
    push_scan(0, 4, 3, 2);
    bs.pre_done = 1; bs.pe_ready = 1; bs.start = 1;
    tick();
    bs.start = 0;
    chk("busy_after_start", int'(bs.busy), 1);
    wait_done(0, 100, 1'b0, cyc);
    chk("start_to_done_edges", cyc, 26);
    chk("busy_with_done", int'(bs.busy), 1);
    tick();
    chk("done_one_cycle", int'(bs.done), 0);
    chk("busy_idle", int'(bs.busy), 0);
    check_totals(0, 24, 6);
    chk("obs_reads", obs_addr.size(), 24);
    if (obs_addr.size() == 24)
      for (int k = 0; k < 24; k++) begin
        chk("lit_address", obs_addr[k], exp12[k % 12]);
        chk("lit_sel", obs_sel[k], k / 12);
      end

    // Preload not finished: no reads until pre_done is sampled
    clr_stats(0);
    push_scan(0, 4, 3, 2);
    bs.pre_done = 0; bs.start = 1;
    tick();
    bs.start = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("wait_pre_no_read", int'(bs.rd8R_en), 1);
      chk("wait_pre_busy", int'(bs.busy), 1);
    end
    bs.pre_done = 1;
    tick();
    chk("pre_done_edge_no_read", int'(bs.rd8R_en), 1);
    tick();
    chk("first_read_en", int'(bs.rd8R_en), 0);
    chk("first_read_addr", int'(bs.rd_address), 0);
    wait_done(0, 100, 1'b0, cyc);
    tick();
    check_totals(0, 24, 6);

    // pe_ready toggling every cycle
    clr_stats(0);
    push_scan(0, 4, 3, 2);
    bs.start = 1;
    tick();
    bs.start = 0;
    wait_done(0, 200, 1'b1, cyc);
    tick();
    check_totals(0, 24, 6);
    bs.pe_ready = 1;

    // Reset in the middle of a scan, then a full scan after release
    clr_stats(0);
    push_scan(0, 4, 3, 2);
    bs.start = 1;
    tick();
    bs.start = 0;
    repeat (8) tick();
    #2 rst_s = 1'b1;
    #1;
    check_reset(0);
    clr_stats(0);
    tick();
    rst_s = 1'b0;
    tick();
    push_scan(0, 4, 3, 2);
    bs.start = 1;
    tick();
    bs.start = 0;
    wait_done(0, 100, 1'b0, cyc);
    tick();
    check_totals(0, 24, 6);

    // Default geometry: abort after 100 reads, then a complete scan
    push_scan(1, 32, 64, 16);
    bd.pre_done = 1; bd.pe_ready = 1; bd.start = 1;
    tick();
    bd.start = 0;
    for (int k = 0; k < 300 && nrd[1] < 100; k++) tick();
    chk("reached_100_reads", int'(nrd[1] >= 100), 1);
    bd.abort = 1;
    tick();
    bd.abort = 0;
    q_rd[1].delete();
    q_tag[1].delete();
    chk("abort_rd8R_en", int'(bd.rd8R_en), 1);
    chk("abort_row_valid", int'(bd.row_valid), 0);
    chk("abort_busy", int'(bd.busy), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("abort_no_done", int'(bd.done), 0);
    end
    clr_stats(1);
    push_scan(1, 32, 64, 16);
    bd.start = 1;
    tick();
    bd.start = 0;
    tick();
    tick();
    chk("restart_addr", int'(bd.rd_address), 0);
    chk("restart_sel", int'(bd.rdR_sel), 0);
    chk("restart_en", int'(bd.rd8R_en), 0);
    wait_done(1, 40000, 1'b0, cyc);
    chk("default_issue_to_done", cyc, 32768);
    tick();
    check_totals(1, 32768, 1024);
    chk("max_rd_address", max_addr[1], 94);
    chk("final_last_vx", last_vx[1], 15);
    chk("final_last_vy", last_vy[1], 63);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
